// File: rtl/ysyx_24110006_wb_sched_pkg.sv
// Shared constants and helpers for the register-file write-back scheduler.
package ysyx_24110006_wb_sched_pkg;

  localparam logic        REQ_EXU = 1'b0;
  localparam logic        REQ_LSU = 1'b1;
  localparam int unsigned NREG    = 16;
  localparam int unsigned IDX_W   = 4;

  // Two-way round-robin pick: on a tie the requester that did not win last goes.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic lg);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = lg ? 2'b01 : 2'b10;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ysyx_24110006_wb_sched_if.sv
// Issue, write-back request and register-file write bundle of the scheduler.
interface ysyx_24110006_wb_sched_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_issue_valid;
  logic                  i_issue_wen;
  logic [ADDR_WIDTH-1:0] i_issue_rd;
  logic [ADDR_WIDTH-1:0] i_issue_rs1;
  logic [ADDR_WIDTH-1:0] i_issue_rs2;
  logic                  o_issue_ready;

  logic                  i_exu_valid;
  logic [ADDR_WIDTH-1:0] i_exu_waddr;
  logic [DATA_WIDTH-1:0] i_exu_wdata;
  logic                  o_exu_ready;

  logic                  i_lsu_valid;
  logic [ADDR_WIDTH-1:0] i_lsu_waddr;
  logic [DATA_WIDTH-1:0] i_lsu_wdata;
  logic                  o_lsu_ready;

  logic                  o_rf_valid;
  logic                  o_rf_wen;
  logic [ADDR_WIDTH-1:0] o_rf_waddr;
  logic [DATA_WIDTH-1:0] o_rf_wdata;

  logic                  o_idle;
  logic                  o_err;

  modport slave (
    input  i_issue_valid, i_issue_wen, i_issue_rd, i_issue_rs1, i_issue_rs2,
    input  i_exu_valid, i_exu_waddr, i_exu_wdata,
    input  i_lsu_valid, i_lsu_waddr, i_lsu_wdata,
    output o_issue_ready, o_exu_ready, o_lsu_ready,
    output o_rf_valid, o_rf_wen, o_rf_waddr, o_rf_wdata, o_idle, o_err
  );

  modport master (
    output i_issue_valid, i_issue_wen, i_issue_rd, i_issue_rs1, i_issue_rs2,
    output i_exu_valid, i_exu_waddr, i_exu_wdata,
    output i_lsu_valid, i_lsu_waddr, i_lsu_wdata,
    input  o_issue_ready, o_exu_ready, o_lsu_ready,
    input  o_rf_valid, o_rf_wen, o_rf_waddr, o_rf_wdata, o_idle, o_err
  );

endinterface

// File: rtl/ysyx_24110006_rr_arb2.sv
// Two-way round-robin arbiter; grants are combinational, last-grant is registered.
module ysyx_24110006_rr_arb2
  import ysyx_24110006_wb_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_c_o
);

  logic lg_q;
  logic lg_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lg_q <= 1'b1;
    end else begin
      lg_q <= lg_d;
    end
  end

  // Nothing is granted while reset is held.
  always_comb begin
    gnt_c_o = 2'b00;
    lg_d    = lg_q;
    if (!rst_i) begin
      gnt_c_o = rr_pick(req_i, lg_q);
    end
    if (gnt_c_o != 2'b00) begin
      lg_d = gnt_c_o[REQ_LSU];
    end
  end

endmodule

// File: rtl/ysyx_24110006_wb_sched.sv
// Write-back scheduler: arbitrates EXU/LSU onto the RF write port and tracks
// per-register busy bits to stall issue on RAW/WAW hazards.
module ysyx_24110006_wb_sched #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREG       = ysyx_24110006_wb_sched_pkg::NREG
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  ysyx_24110006_wb_sched_if.slave  bus
);
  import ysyx_24110006_wb_sched_pkg::*;

  logic [NREG-1:0]       busy_q,     busy_d;
  logic                  rf_valid_q, rf_valid_d;
  logic                  rf_wen_q,   rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  err_q,      err_d;

  logic [1:0]            req_c;
  logic [1:0]            gnt_c;
  logic                  grant_c;
  logic [ADDR_WIDTH-1:0] g_waddr_c;
  logic [DATA_WIDTH-1:0] g_wdata_c;
  logic [IDX_W-1:0]      g_idx_c, clr_idx_c, rd_idx_c, rs1_idx_c, rs2_idx_c;
  logic                  clr_c, issue_set_c, issue_ready_c;
  logic                  unused_hi_c;

  assign req_c = {bus.i_lsu_valid, bus.i_exu_valid};

  ysyx_24110006_rr_arb2 u_arb (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .req_i   (req_c),
    .gnt_c_o (gnt_c)
  );

  // Hazard check sees only the registered busy bits; a same-cycle clear does not bypass.
  always_comb begin
    rd_idx_c      = bus.i_issue_rd[IDX_W-1:0];
    rs1_idx_c     = bus.i_issue_rs1[IDX_W-1:0];
    rs2_idx_c     = bus.i_issue_rs2[IDX_W-1:0];
    issue_ready_c = !(busy_q[rs1_idx_c] && (rs1_idx_c != '0)) &&
                    !(busy_q[rs2_idx_c] && (rs2_idx_c != '0)) &&
                    !(bus.i_issue_wen && (rd_idx_c != '0) && busy_q[rd_idx_c]);
  end

  assign unused_hi_c = ^{bus.i_issue_rd[ADDR_WIDTH-1:IDX_W],
                         bus.i_issue_rs1[ADDR_WIDTH-1:IDX_W],
                         bus.i_issue_rs2[ADDR_WIDTH-1:IDX_W]};

  always_comb begin
    busy_d     = busy_q;
    rf_valid_d = 1'b0;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q;

    grant_c     = (gnt_c != 2'b00);
    g_waddr_c   = gnt_c[REQ_LSU] ? bus.i_lsu_waddr : bus.i_exu_waddr;
    g_wdata_c   = gnt_c[REQ_LSU] ? bus.i_lsu_wdata : bus.i_exu_wdata;
    g_idx_c     = g_waddr_c[IDX_W-1:0];
    clr_c       = rf_valid_q && rf_wen_q;
    clr_idx_c   = rf_waddr_q[IDX_W-1:0];
    issue_set_c = bus.i_issue_valid && issue_ready_c && bus.i_issue_wen && (rd_idx_c != '0);

    if (grant_c && (g_idx_c != '0) && !busy_q[g_idx_c] && !(clr_c && (clr_idx_c == g_idx_c))) begin
      err_d = 1'b1;
    end

    // Clear first so a same-edge set on the same entry wins.
    if (clr_c) begin
      busy_d[clr_idx_c] = 1'b0;
    end
    if (issue_set_c) begin
      busy_d[rd_idx_c] = 1'b1;
    end

    if (grant_c) begin
      rf_valid_d = 1'b1;
      rf_wen_d   = (g_idx_c != '0);
      rf_waddr_d = g_waddr_c;
      rf_wdata_d = g_wdata_c;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy_q     <= '0;
      rf_valid_q <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rf_valid_q <= rf_valid_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_issue_ready = issue_ready_c;
  assign bus.o_exu_ready   = gnt_c[REQ_EXU];
  assign bus.o_lsu_ready   = gnt_c[REQ_LSU];
  assign bus.o_rf_valid    = rf_valid_q;
  assign bus.o_rf_wen      = rf_wen_q;
  assign bus.o_rf_waddr    = rf_waddr_q;
  assign bus.o_rf_wdata    = rf_wdata_q;
  assign bus.o_err         = err_q;
  assign bus.o_idle        = (busy_q == '0) && !rf_valid_q;

endmodule

// File: tb/tb_ysyx_24110006_wb_sched.sv
// Self-checking bench for the write-back scheduler: per-cycle model compare plus
// directed scenarios with hand-computed expectations.
module tb_ysyx_24110006_wb_sched;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   check_en;

  ysyx_24110006_wb_sched_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  ysyx_24110006_wb_sched #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREG(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: set of busy registers, pending RF write, who won last, sticky error.
  logic [15:0] m_busy;
  logic        m_last_lsu;
  logic        m_v, m_wen, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic bit f_ready();
    int r1, r2, rd;
    r1 = int'(bus.i_issue_rs1[3:0]);
    r2 = int'(bus.i_issue_rs2[3:0]);
    rd = int'(bus.i_issue_rd[3:0]);
    if (r1 != 0 && m_busy[r1]) return 1'b0;
    if (r2 != 0 && m_busy[r2]) return 1'b0;
    if (bus.i_issue_wen && rd != 0 && m_busy[rd]) return 1'b0;
    return 1'b1;
  endfunction

  // -1: nobody, 0: EXU, 1: LSU
  function automatic int f_winner();
    if (rst) return -1;
    if (bus.i_exu_valid && bus.i_lsu_valid) return m_last_lsu ? 0 : 1;
    if (bus.i_exu_valid) return 0;
    if (bus.i_lsu_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] nb;
    int          w;
    logic [4:0]  wa;
    logic [31:0] wd;
    if (rst) begin
      m_busy     <= '0;
      m_last_lsu <= 1'b1;
      m_v        <= 1'b0;
      m_wen      <= 1'b0;
      m_addr     <= '0;
      m_data     <= '0;
      m_err      <= 1'b0;
    end else begin
      w  = f_winner();
      wa = (w == 1) ? bus.i_lsu_waddr : bus.i_exu_waddr;
      wd = (w == 1) ? bus.i_lsu_wdata : bus.i_exu_wdata;
      nb = m_busy;
      if (w >= 0 && wa[3:0] != 0 && !m_busy[wa[3:0]] && !(m_v && m_wen && m_addr[3:0] == wa[3:0]))
        m_err <= 1'b1;
      if (m_v && m_wen) nb[m_addr[3:0]] = 1'b0;
      if (bus.i_issue_valid && f_ready() && bus.i_issue_wen && bus.i_issue_rd[3:0] != 0)
        nb[bus.i_issue_rd[3:0]] = 1'b1;
      m_busy <= nb;
      m_v    <= (w >= 0);
      m_wen  <= (w >= 0) && (wa[3:0] != 0);
      if (w >= 0) begin
        m_addr     <= wa;
        m_data     <= wd;
        m_last_lsu <= (w == 1);
      end
    end
  end

  always @(negedge clk) begin : compare
    int w;
    if (check_en) begin
      w = f_winner();
      chk("issue_ready", 32'(bus.o_issue_ready), 32'(f_ready()));
      chk("exu_ready",   32'(bus.o_exu_ready),   32'(w == 0));
      chk("lsu_ready",   32'(bus.o_lsu_ready),   32'(w == 1));
      chk("rf_valid",    32'(bus.o_rf_valid),    32'(m_v));
      chk("rf_wen",      32'(bus.o_rf_wen),      32'(m_wen));
      chk("rf_waddr",    32'(bus.o_rf_waddr),    32'(m_addr));
      chk("rf_wdata",    bus.o_rf_wdata,         m_data);
      chk("err",         32'(bus.o_err),         32'(m_err));
      chk("idle",        32'(bus.o_idle),        32'((m_busy == 16'h0) && !m_v));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_issue(input logic v, input logic wen, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2);
    bus.i_issue_valid = v;
    bus.i_issue_wen   = wen;
    bus.i_issue_rd    = rd;
    bus.i_issue_rs1   = rs1;
    bus.i_issue_rs2   = rs2;
  endtask

  task automatic drv_exu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.i_exu_valid = v;
    bus.i_exu_waddr = a;
    bus.i_exu_wdata = d;
  endtask

  task automatic drv_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.i_lsu_valid = v;
    bus.i_lsu_waddr = a;
    bus.i_lsu_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_seq [4];
    total    = 0;
    bad      = 0;
    check_en = 1'b0;
    clk      = 1'b0;
    rst      = 1'b1;
    drv_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drv_exu(1'b0, 5'd0, 32'h0);
    drv_lsu(1'b0, 5'd0, 32'h0);
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("reset_idle", 32'(bus.o_idle), 32'd1);
    chk("reset_ready", 32'(bus.o_issue_ready), 32'd1);
    chk("reset_rf_valid", 32'(bus.o_rf_valid), 32'd0);

    // Issue rd=5, then a reader of x5 stalls.
    drv_issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    #1 chk("issue_rd5_ready", 32'(bus.o_issue_ready), 32'd1);
    tick();
    drv_issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
    #1;
    chk("busy5_idle", 32'(bus.o_idle), 32'd0);
    chk("raw_x5_stall", 32'(bus.o_issue_ready), 32'd0);

    // EXU writes x5 while the reader waits.
    drv_exu(1'b1, 5'd5, 32'h1234);
    #1 chk("exu_grant", 32'(bus.o_exu_ready), 32'd1);
    tick();
    drv_exu(1'b0, 5'd0, 32'h0);
    #1;
    chk("wb_valid", 32'(bus.o_rf_valid), 32'd1);
    chk("wb_waddr", 32'(bus.o_rf_waddr), 32'd5);
    chk("wb_wdata", bus.o_rf_wdata, 32'h1234);
    chk("still_stalled", 32'(bus.o_issue_ready), 32'd0);
    tick();
    #1;
    chk("raw_released", 32'(bus.o_issue_ready), 32'd1);
    chk("idle_again", 32'(bus.o_idle), 32'd1);
    drv_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // Contention: fresh last-grant, x3 and x4 busy, both requesters held 4 cycles.
    do_reset();
    drv_issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    drv_issue(1'b1, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    drv_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drv_exu(1'b1, 5'd3, 32'hAAAA_0003);
    drv_lsu(1'b1, 5'd4, 32'hBBBB_0004);
    exp_seq[0] = 5'd3;
    exp_seq[1] = 5'd4;
    exp_seq[2] = 5'd3;
    exp_seq[3] = 5'd4;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_waddr%0d", i), 32'(bus.o_rf_waddr), 32'(exp_seq[i]));
    end
    drv_exu(1'b0, 5'd0, 32'h0);
    drv_lsu(1'b0, 5'd0, 32'h0);
    #1 chk("rr_rewrite_err", 32'(bus.o_err), 32'd1);
    tick();

    // x0 targets never mark busy and never write.
    do_reset();
    drv_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1 chk("rd0_ready", 32'(bus.o_issue_ready), 32'd1);
    tick();
    drv_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 chk("rd0_idle", 32'(bus.o_idle), 32'd1);
    drv_lsu(1'b1, 5'd0, 32'h55);
    tick();
    drv_lsu(1'b0, 5'd0, 32'h0);
    #1;
    chk("x0_valid", 32'(bus.o_rf_valid), 32'd1);
    chk("x0_wen", 32'(bus.o_rf_wen), 32'd0);
    chk("x0_err", 32'(bus.o_err), 32'd0);

    // Write-back to a non-busy register is sticky until reset.
    drv_lsu(1'b1, 5'd7, 32'h77);
    tick();
    drv_lsu(1'b0, 5'd0, 32'h0);
    #1 chk("err_set", 32'(bus.o_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("err_sticky%0d", i), 32'(bus.o_err), 32'd1);
    end

    // Reset while a write sits in the output register.
    do_reset();
    drv_issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    tick();
    drv_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drv_exu(1'b1, 5'd9, 32'h99);
    tick();
    drv_exu(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    drv_lsu(1'b1, 5'd9, 32'h66);
    #1;
    chk("rst_no_grant", 32'(bus.o_lsu_ready), 32'd0);
    chk("pending_strobe", 32'(bus.o_rf_valid), 32'd1);
    tick();
    rst = 1'b0;
    drv_lsu(1'b0, 5'd0, 32'h0);
    drv_issue(1'b1, 1'b0, 5'd0, 5'd9, 5'd0);
    #1;
    chk("rst_drop_valid", 32'(bus.o_rf_valid), 32'd0);
    chk("rst_ready", 32'(bus.o_issue_ready), 32'd1);
    chk("rst_idle", 32'(bus.o_idle), 32'd1);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    tick();
    drv_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();
    tick();

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_wb_sched.md
# ysyx_24110006_wb_sched

Write-back scheduler for the core's register file. Arbitrates two write-back requesters (EXU results, LSU load data) onto the single register-file write port. Also keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards. Sits between IDU/EXU/LSU and the register file, and drives its `i_valid`/`i_wen`/`i_waddr`/`i_wdata`.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width; only bits [3:0] are used (RV32E, 16 registers)
- DATA_WIDTH, 32, write-back data width
- NREG, 16, number of scoreboard entries

Ports:
- i_clock  in  1  single clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_issue_valid  in  1  IDU presents an instruction
- i_issue_wen  in  1  instruction writes rd
- i_issue_rd  in  ADDR_WIDTH  destination register
- i_issue_rs1, i_issue_rs2  in  ADDR_WIDTH  source registers
- o_issue_ready  out  1  no hazard; issue accepted when valid && ready
- i_exu_valid  in  1  EXU write-back request
- i_exu_waddr  in  ADDR_WIDTH  EXU destination
- i_exu_wdata  in  DATA_WIDTH  EXU result
- o_exu_ready  out  1  EXU request granted this cycle
- i_lsu_valid, i_lsu_waddr, i_lsu_wdata, o_lsu_ready: same as EXU, for the LSU
- o_rf_valid  out  1  register-file write strobe (drives RF `i_valid`)
- o_rf_wen  out  1  register-file write enable
- o_rf_waddr  out  ADDR_WIDTH  register-file write address
- o_rf_wdata  out  DATA_WIDTH  register-file write data
- o_idle  out  1  no busy bits set and no write pending in the output register
- o_err  out  1  sticky: a write-back arrived for a non-busy register

## Operation
- Scoreboard: a busy[NREG] bit vector, indexed by addr[3:0]. Entry 0 is never set.
- Hazard logic: o_issue_ready = !(busy[rs1] && rs1!=0) && !(busy[rs2] && rs2!=0) && !(i_issue_wen && rd!=0 && busy[rd]).
  - Ready is computed from the current busy bits only. A clear in the same cycle does not bypass into ready.
- On issue handshake with i_issue_wen && rd!=0: set busy[rd] at the edge.
- Arbitration is round-robin between the two requesters, using a last-grant register lg (0 = EXU, 1 = LSU):
  - Only one requester valid: grant it.
  - Both valid: grant the requester not equal to lg.
  - lg is updated on every grant.
- At most one grant per cycle. o_exu_ready and o_lsu_ready are combinational from the valids and lg. The requester holds its valid, waddr and wdata until granted.
- The output register captures the granted request. The RF accepts every write, so the output register never back-pressures.
  - On a grant: next cycle o_rf_valid=1, o_rf_wen=(waddr[3:0]!=0), o_rf_waddr/o_rf_wdata = granted values.
  - No grant: o_rf_valid=0, o_rf_wen=0; waddr/wdata hold their previous values.
- Busy clear: at the edge where o_rf_valid && o_rf_wen, clear busy[o_rf_waddr]. This is the same edge at which the RF commits, so a stalled reader sees the new value the following cycle.
- If a set and a clear hit the same entry at the same edge, the set wins. This only arises when an issue was accepted; normally WAW prevents it.
- Error: when a grant targets waddr!=0 with busy[waddr]==0 and no clear is pending for it in the output register, o_err sets and stays set until reset.
- o_idle = (busy==0) && !o_rf_valid.

## Timing
- Reset values (sync, active-high):
  - busy = 0, lg = 1 (EXU wins the first tie).
  - o_rf_valid = 0, o_rf_wen = 0, o_rf_waddr = 0, o_rf_wdata = 0, o_err = 0.
  - Consequently o_idle = 1 and o_issue_ready = 1 one cycle after reset.
- Reset mid-operation discards the pending output write and all busy bits. In-flight requesters are not granted during the reset cycle (ready=0 while i_reset).
- Write-back latency: grant at cycle N; RF write strobe at N+1; RF commit and busy clear at the end of N+1; a dependent issue becomes ready at N+2.
- Throughput: one write-back per cycle. Under continuous contention, grants alternate EXU, LSU, EXU, ...

## Structure
- Shared package: requester index constants (REQ_EXU=0, REQ_LSU=1), NREG, and the register-index slice width (4).
- Natural sub-module: ysyx_24110006_rr_arb2, a two-way round-robin arbiter holding lg and producing one-hot grants.
- Scoreboard and output register stay in this module.

## Test plan
- Reset, then issue rd=5: o_issue_ready=1, busy[5]=1, o_idle=0. A following issue with rs1=5 gets o_issue_ready=0.
- EXU writes x5=0x1234 at cycle N: o_rf_valid=1, waddr=5, wdata=0x1234 at N+1. The rs1=5 issue gets ready=1 at N+2, and o_idle=1 once nothing else is busy.
- EXU and LSU both valid for 4 cycles, targeting busy x3 and x4: grants go EXU, LSU, EXU, LSU, and o_rf_waddr sequence is 3, 4, 3, 4.
- Issue rd=0 or rs1=0: o_issue_ready=1 and busy stays 0. LSU write to x0 gives o_rf_valid=1, o_rf_wen=0, o_err=0.
- LSU write to non-busy x7: o_err=1 next cycle and stays 1 until i_reset.
- Assert i_reset in the cycle between grant and RF strobe: next cycle o_rf_valid=0, busy=0, o_issue_ready=1.
